// File: rtl/morse_pkg.sv
// Shared definitions for the Morse keying controller: state encoding,
// element/gap lengths in Morse units and the symbol encoding.
package morse_pkg;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_FETCH = 3'd1,
      ST_MARK  = 3'd2,
      ST_IGAP  = 3'd3,
      ST_CGAP  = 3'd4,
      ST_WGAP  = 3'd5
   } state_t;

   localparam logic [2:0] DOT_UNITS        = 3'd1;
   localparam logic [2:0] DASH_UNITS       = 3'd3;
   localparam logic [2:0] IGAP_UNITS       = 3'd1;
   localparam logic [2:0] CGAP_UNITS       = 3'd3;
   localparam logic [2:0] WGAP_EXTRA_UNITS = 3'd4;

   localparam logic SYM_DASH = 1'b1;

   // Length of the current state in units; states without a timed length return 1.
   function automatic logic [2:0] units_for(input state_t st, input logic dash);
      logic [2:0] n;
      n = 3'd1;
      case (st)
         ST_MARK: n = dash ? DASH_UNITS : DOT_UNITS;
         ST_IGAP: n = IGAP_UNITS;
         ST_CGAP: n = CGAP_UNITS;
         ST_WGAP: n = WGAP_EXTRA_UNITS;
         default: n = 3'd1;
      endcase
      return n;
   endfunction

endpackage

// File: rtl/morse_unit_timer.sv
// Two-level timer: a prescaler dividing the clock into Morse units and a
// unit counter; last_cycle flags the final clock cycle of an N-unit interval.
module morse_unit_timer #(
   parameter int UNIT_CYCLES = 4
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       clear,
   input  logic [2:0] units,
   output logic       last_cycle
);

   localparam int PRE_W = (UNIT_CYCLES > 1) ? $clog2(UNIT_CYCLES) : 1;
   localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(UNIT_CYCLES - 1);

   logic [PRE_W-1:0] pre_q, pre_d;
   logic [2:0]       unit_q, unit_d;
   logic             pre_wrap, unit_wrap;

   always_comb begin
      pre_wrap   = (pre_q == PRE_MAX);
      unit_wrap  = (unit_q == (units - 3'd1));
      last_cycle = pre_wrap & unit_wrap;
      pre_d      = pre_wrap ? '0 : pre_q + PRE_W'(1);
      unit_d     = unit_q;
      if (pre_wrap) begin
         unit_d = unit_wrap ? 3'd0 : unit_q + 3'd1;
      end
      if (clear) begin
         pre_d  = '0;
         unit_d = 3'd0;
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         pre_q  <= '0;
         unit_q <= 3'd0;
      end else begin
         pre_q  <= pre_d;
         unit_q <= unit_d;
      end
   end

endmodule

// File: rtl/morse_keyer.sv
// Morse keying controller: takes one character per handshake from code_reg,
// walks its symbols and drives a registered, glitch-free key line.
//
//   state | meaning
//   IDLE  | ready for a character; char_load on handshake
//   FETCH | code_reg loaded; pick space or first element
//   MARK  | key high for 1 (dot) or 3 (dash) units; shift on last cycle
//   IGAP  | key low 1 unit between elements of one character
//   CGAP  | key low 3 units after the last element
//   WGAP  | key low 4 units for a space (7 with the preceding CGAP)
module morse_keyer
   import morse_pkg::*;
#(
   parameter int UNIT_CYCLES = 4
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       char_valid,
   output logic       char_ready,
   output logic       char_load,
   output logic       shft_cnt,
   input  logic [3:0] cntr_data,
   input  logic       shft_data,
   input  logic       abort,
   output logic       key_out,
   output logic       busy
);

   state_t     state_q, state_d;
   logic       dash_q, dash_d;
   logic       key_out_q, key_out_d;
   logic       busy_q, busy_d;
   logic       char_ready_q, char_ready_d;
   logic       timer_clear;
   logic [2:0] timer_units;
   logic       last_cycle;

   morse_unit_timer #(
      .UNIT_CYCLES(UNIT_CYCLES)
   ) u_timer (
      .clock      (clock),
      .reset      (reset),
      .clear      (timer_clear),
      .units      (timer_units),
      .last_cycle (last_cycle)
   );

   always_comb begin
      state_d     = state_q;
      dash_d      = dash_q;
      timer_units = units_for(state_q, dash_q);
      case (state_q)
         ST_IDLE: begin
            if (char_valid && char_ready_q) state_d = ST_FETCH;
         end
         ST_FETCH: begin
            if (cntr_data == 4'd0) begin
               state_d = ST_WGAP;
            end else begin
               dash_d  = (shft_data == SYM_DASH);
               state_d = ST_MARK;
            end
         end
         ST_MARK: begin
            if (last_cycle) state_d = (cntr_data == 4'd1) ? ST_CGAP : ST_IGAP;
         end
         ST_IGAP: begin
            if (last_cycle) begin
               dash_d  = (shft_data == SYM_DASH);
               state_d = ST_MARK;
            end
         end
         ST_CGAP, ST_WGAP: begin
            if (last_cycle) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
      if (abort && (state_q != ST_IDLE)) state_d = ST_IDLE;

      // Timer only runs inside timed states and restarts on every transition.
      timer_clear  = (state_d != state_q) || (state_q == ST_IDLE) || (state_q == ST_FETCH);
      key_out_d    = (state_d == ST_MARK);
      busy_d       = (state_d != ST_IDLE);
      char_ready_d = (state_d == ST_IDLE);

      char_load = char_valid & char_ready_q & (state_q == ST_IDLE);
      shft_cnt  = (state_q == ST_MARK) & last_cycle & ~abort;
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q      <= ST_IDLE;
         dash_q       <= 1'b0;
         key_out_q    <= 1'b0;
         busy_q       <= 1'b0;
         char_ready_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         dash_q       <= dash_d;
         key_out_q    <= key_out_d;
         busy_q       <= busy_d;
         char_ready_q <= char_ready_d;
      end
   end

   assign key_out    = key_out_q;
   assign busy       = busy_q;
   assign char_ready = char_ready_q;

endmodule

// File: tb/tb_morse_keyer.sv
// Bench for morse_keyer with UNIT_CYCLES=2 and a behavioural code_reg attached;
// each character's expected key segments are queued and checked by a monitor.
module tb_morse_keyer;

   localparam int U = 2;

   typedef int seg_t [10];
   typedef struct {
      seg_t segs;
      int   nseg;
      int   nshft;
      int   busy;
      int   end_cnt;
      int   pre_idle;
   } exp_t;

   logic       clock = 1'b0;
   logic       reset = 1'b0;
   logic       char_valid = 1'b0;
   logic       abort = 1'b0;
   logic [7:0] charcode = 8'h00;
   logic [3:0] charlen = 4'd0;
   logic       char_ready, char_load, shft_cnt, key_out, busy;
   logic [3:0] cntr_data;
   logic       shft_data;
   logic [7:0] pat_q = 8'h00;
   logic [3:0] cnt_q = 4'd0;

   int tests = 0;
   int fails = 0;
   int sends = 0;
   int loads = 0;

   exp_t exp_q [$];
   exp_t cur;
   logic in_win = 1'b0;
   logic run_lvl = 1'b0;
   logic shft_pend = 1'b0;
   int   run_len = 0;
   int   seg_idx = 0;
   int   shft_n = 0;
   int   busy_n = 0;
   int   idle_n = 0;

   morse_keyer #(.UNIT_CYCLES(U)) dut (
      .clock      (clock),
      .reset      (reset),
      .char_valid (char_valid),
      .char_ready (char_ready),
      .char_load  (char_load),
      .shft_cnt   (shft_cnt),
      .cntr_data  (cntr_data),
      .shft_data  (shft_data),
      .abort      (abort),
      .key_out    (key_out),
      .busy       (busy)
   );

   always #5 clock = ~clock;

   // code_reg: MSB-first pattern plus remaining-symbol count
   always @(posedge clock) begin
      if (char_load) begin
         pat_q <= charcode;
         cnt_q <= charlen;
      end else if (shft_cnt) begin
         pat_q <= {pat_q[6:0], 1'b0};
         cnt_q <= cnt_q - 4'd1;
      end
   end
   assign shft_data = pat_q[7];
   assign cntr_data = cnt_q;

   task automatic check(input string name, input int act, input int exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   function automatic exp_t mk(input seg_t s, input int nshft, input int bsy,
                               input int endc, input int idle);
      exp_t e;
      e.segs = s;
      e.nseg = 0;
      for (int i = 0; i < 10; i++) if (s[i] != 0) e.nseg = i + 1;
      e.nshft    = nshft;
      e.busy     = bsy;
      e.end_cnt  = endc;
      e.pre_idle = idle;
      return e;
   endfunction

   task automatic emit_seg();
      int v;
      v = run_lvl ? run_len : -run_len;
      if (seg_idx < cur.nseg) check($sformatf("seg%0d", seg_idx), v, cur.segs[seg_idx]);
      else check("extra_seg", v, 0);
      seg_idx++;
   endtask

   always @(negedge clock) begin
      if (shft_pend) begin
         check("key_low_after_shft", int'(key_out), 0);
         shft_pend = 1'b0;
      end
      if (char_load) begin
         loads++;
         check("load_not_busy", int'(busy), 0);
      end
      if (busy) begin
         if (!in_win) begin
            if (exp_q.size() == 0) begin
               check("unexpected_busy", 1, 0);
               cur.nseg = 0; cur.nshft = 0; cur.busy = 0; cur.end_cnt = 0; cur.pre_idle = -1;
            end else begin
               cur = exp_q.pop_front();
            end
            if (cur.pre_idle >= 0) check("idle_gap", idle_n, cur.pre_idle);
            in_win  = 1'b1;
            run_lvl = key_out;
            run_len = 1;
            seg_idx = 0;
            shft_n  = 0;
            busy_n  = 1;
         end else begin
            busy_n++;
            if (key_out == run_lvl) run_len++;
            else begin
               emit_seg();
               run_lvl = key_out;
               run_len = 1;
            end
         end
         if (shft_cnt) begin
            shft_n++;
            check("key_high_at_shft", int'(key_out), 1);
            shft_pend = 1'b1;
         end
      end else begin
         if (in_win) begin
            emit_seg();
            check("seg_count", seg_idx, cur.nseg);
            check("shft_pulses", shft_n, cur.nshft);
            check("busy_cycles", busy_n, cur.busy);
            check("cntr_end", int'(cntr_data), cur.end_cnt);
            in_win = 1'b0;
            idle_n = 0;
         end
         idle_n++;
         if (shft_cnt) check("shft_while_idle", 1, 0);
      end
   end

   task automatic wait_ready(output bit ok);
      int waited;
      waited = 0;
      @(negedge clock);
      while (!char_ready && waited < 300) begin
         @(negedge clock);
         waited++;
      end
      ok = char_ready;
      if (!ok) check("ready_timeout", 0, 1);
   endtask

   task automatic send(input logic [7:0] code, input logic [3:0] len, input exp_t e);
      bit ok;
      wait_ready(ok);
      if (ok) begin
         exp_q.push_back(e);
         sends++;
         char_valid = 1'b1;
         charcode   = code;
         charlen    = len;
         @(posedge clock);
         #1 char_valid = 1'b0;
      end
   endtask

   initial begin
      exp_t e_e, e_e1, e_t, e_l, e_k, e_sp, e_ab, e_rst;
      bit ok;
      int waited;

      e_e1  = mk('{-1, 2, -6, 0, 0, 0, 0, 0, 0, 0}, 1, 9, 0, -1);
      e_e   = mk('{-1, 2, -6, 0, 0, 0, 0, 0, 0, 0}, 1, 9, 0, 1);
      e_t   = mk('{-1, 6, -6, 0, 0, 0, 0, 0, 0, 0}, 1, 13, 0, 1);
      e_l   = mk('{-1, 2, -2, 6, -2, 2, -2, 2, -6, 0}, 4, 25, 0, 1);
      e_k   = mk('{-1, 6, -2, 2, -2, 6, -6, 0, 0, 0}, 3, 25, 0, 1);
      e_sp  = mk('{-9, 0, 0, 0, 0, 0, 0, 0, 0, 0}, 0, 9, 0, 1);
      e_ab  = mk('{-1, 2, -2, 3, 0, 0, 0, 0, 0, 0}, 1, 8, 3, -1);
      e_rst = mk('{-1, 1, 0, 0, 0, 0, 0, 0, 0, 0}, 0, 2, 1, -1);

      repeat (3) @(negedge clock);
      check("rst_key_out", int'(key_out), 0);
      check("rst_busy", int'(busy), 0);
      check("rst_char_ready", int'(char_ready), 0);
      check("rst_shft_cnt", int'(shft_cnt), 0);
      check("rst_char_load", int'(char_load), 0);
      reset = 1'b1;
      #1 check("ready_before_edge", int'(char_ready), 0);
      @(posedge clock);
      #1 check("ready_after_edge", int'(char_ready), 1);

      send(8'h00, 4'd1, e_e1);
      send(8'h80, 4'd1, e_t);
      send(8'b0100_0000, 4'd4, e_l);
      send(8'b1010_0000, 4'd3, e_k);
      send(8'h00, 4'd1, e_e);
      send(8'h00, 4'd0, e_sp);
      send(8'h00, 4'd1, e_e);

      // abort during the dash of 'L' while char_valid stays high; 'E' follows
      wait_ready(ok);
      if (ok) begin
         exp_q.push_back(e_ab);
         exp_q.push_back(e_e);
         sends += 2;
         char_valid = 1'b1;
         charcode   = 8'b0100_0000;
         charlen    = 4'd4;
         @(posedge clock);
         #1 charcode = 8'h00;
         charlen = 4'd1;
         repeat (7) @(posedge clock);
         #1 abort = 1'b1;
         @(posedge clock);
         #1 abort = 1'b0;
         check("abort_key_low", int'(key_out), 0);
         check("abort_idle_ready", int'(char_ready), 1);
         @(posedge clock);
         #1 char_valid = 1'b0;
      end

      // asynchronous reset during the dash of 'T'
      wait_ready(ok);
      if (ok) begin
         exp_q.push_back(e_rst);
         sends++;
         char_valid = 1'b1;
         charcode   = 8'h80;
         charlen    = 4'd1;
         @(posedge clock);
         #1 char_valid = 1'b0;
         repeat (2) @(posedge clock);
         #1 check("key_high_before_reset", int'(key_out), 1);
         #2 reset = 1'b0;
         #1 check("key_low_async_reset", int'(key_out), 0);
         check("busy_low_async_reset", int'(busy), 0);
         repeat (2) @(negedge clock);
         reset = 1'b1;
         #1 check("ready_low_after_release", int'(char_ready), 0);
         @(posedge clock);
         #1 check("ready_high_after_release", int'(char_ready), 1);
      end

      send(8'h00, 4'd1, e_e1);

      waited = 0;
      while ((exp_q.size() != 0 || in_win) && waited < 500) begin
         @(negedge clock);
         waited++;
      end
      @(negedge clock);
      check("drain_pending", exp_q.size() + int'(in_win), 0);
      check("load_count", loads, sends);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
